// File: rtl/spi_lcd_write_if.sv
// Requester-side handshake for the LCD byte serialiser: a Start/Done level handshake
// that carries the 10-bit word {CS_n, A0, byte}.
interface spi_lcd_write_if;
    logic       Start_Sig;
    logic [9:0] SPI_Data;
    logic       Done_Sig;
    logic       Busy_Sig;

    modport master (output Start_Sig, SPI_Data, input Done_Sig, Busy_Sig);
    modport slave  (input Start_Sig, SPI_Data, output Done_Sig, Busy_Sig);
endinterface

// File: rtl/spi_lcd_write_module.sv
// MSB-first byte serialiser for the 12864 LCD.
// SCLK idles high, and the LCD samples SDA on each SCLK rising edge.
//
// state | meaning
// IDLE  | CSn high, SCLK high, waiting for Start_Sig
// SETUP | chip-select setup time, HALF_DIV cycles
// LOW   | SCLK low, SDA presents the current bit
// HIGH  | SCLK high, the LCD samples the bit
// DONE  | one-cycle Done_Sig, CSn/A0/SDA held
module spi_lcd_write_module #(
    parameter int HALF_DIV = 4
) (
    input  logic              CLK,
    input  logic              RSTn,
    spi_lcd_write_if.slave    bus,
    output logic              LCD_CSn,
    output logic              LCD_A0,
    output logic              LCD_SCLK,
    output logic              LCD_SDA
);
    typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, DONE} state_t;

    localparam logic [7:0] DIV_LOAD = 8'(HALF_DIV - 1);

    state_t     state;
    logic [7:0] div_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic [2:0] bit_nxt;

    assign bit_nxt = bit_cnt - 3'd1;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state        <= IDLE;
            div_cnt      <= '0;
            bit_cnt      <= '0;
            shift        <= '0;
            bus.Done_Sig <= 1'b0;
            bus.Busy_Sig <= 1'b0;
            LCD_CSn      <= 1'b1;
            LCD_A0       <= 1'b1;
            LCD_SCLK     <= 1'b1;
            LCD_SDA      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    LCD_CSn  <= 1'b1;
                    LCD_SCLK <= 1'b1;
                    if (bus.Start_Sig) begin
                        shift        <= bus.SPI_Data[7:0];
                        LCD_CSn      <= bus.SPI_Data[9];
                        LCD_A0       <= bus.SPI_Data[8];
                        bit_cnt      <= 3'd7;
                        div_cnt      <= DIV_LOAD;
                        bus.Busy_Sig <= 1'b1;
                        state        <= SETUP;
                    end
                end
                SETUP: begin
                    if (div_cnt == 8'd0) begin
                        div_cnt  <= DIV_LOAD;
                        LCD_SCLK <= 1'b0;
                        LCD_SDA  <= shift[bit_cnt];
                        state    <= LOW;
                    end else begin
                        div_cnt <= div_cnt - 8'd1;
                    end
                end
                LOW: begin
                    if (div_cnt == 8'd0) begin
                        div_cnt  <= DIV_LOAD;
                        LCD_SCLK <= 1'b1;
                        state    <= HIGH;
                    end else begin
                        div_cnt <= div_cnt - 8'd1;
                    end
                end
                HIGH: begin
                    if (div_cnt == 8'd0) begin
                        div_cnt <= DIV_LOAD;
                        if (bit_cnt == 3'd0) begin
                            bus.Done_Sig <= 1'b1;
                            state        <= DONE;
                        end else begin
                            bit_cnt  <= bit_nxt;
                            LCD_SCLK <= 1'b0;
                            LCD_SDA  <= shift[bit_nxt];
                            state    <= LOW;
                        end
                    end else begin
                        div_cnt <= div_cnt - 8'd1;
                    end
                end
                DONE: begin
                    // A0 is deliberately left alone so it keeps its last value while idle.
                    div_cnt      <= DIV_LOAD;
                    bus.Done_Sig <= 1'b0;
                    bus.Busy_Sig <= 1'b0;
                    LCD_CSn      <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_lcd_write_module.sv
// Directed bench for spi_lcd_write_module: one instance at HALF_DIV=4, one at HALF_DIV=1.
module tb_spi_lcd_write_module;
    logic CLK = 1'b0;
    logic RSTn;
    always #5 CLK = ~CLK;

    spi_lcd_write_if bus4 ();
    spi_lcd_write_if bus1 ();
    logic csn4, a04, sclk4, sda4;
    logic csn1, a01, sclk1, sda1;

    spi_lcd_write_module #(.HALF_DIV(4)) dut4 (
        .CLK(CLK), .RSTn(RSTn), .bus(bus4.slave),
        .LCD_CSn(csn4), .LCD_A0(a04), .LCD_SCLK(sclk4), .LCD_SDA(sda4));
    spi_lcd_write_module #(.HALF_DIV(1)) dut1 (
        .CLK(CLK), .RSTn(RSTn), .bus(bus1.slave),
        .LCD_CSn(csn1), .LCD_A0(a01), .LCD_SCLK(sclk1), .LCD_SDA(sda1));

    int checks = 0;
    int failures = 0;
    int done_cnt4 = 0;

    always @(negedge CLK) if (bus4.Done_Sig === 1'b1) done_cnt4++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic sclk_of(input bit s); return s ? sclk1 : sclk4; endfunction
    function automatic logic sda_of(input bit s);  return s ? sda1 : sda4;   endfunction
    function automatic logic csn_of(input bit s);  return s ? csn1 : csn4;   endfunction
    function automatic logic a0_of(input bit s);   return s ? a01 : a04;     endfunction
    function automatic logic done_of(input bit s); return s ? bus1.Done_Sig : bus4.Done_Sig; endfunction
    function automatic logic busy_of(input bit s); return s ? bus1.Busy_Sig : bus4.Busy_Sig; endfunction

    // Called with the sample just after E0 (n=0); returns when Done_Sig is seen or the budget expires.
    task automatic watch(input bit s, input int h, input logic [9:0] data,
                         output logic [7:0] rx, output int done_at);
        int n = 0;
        int rises = 0;
        int bad_rise = 0;
        int bad_hold = 0;
        logic prev;
        prev = sclk_of(s);
        rx = '0;
        done_at = -1;
        while (done_at < 0 && n < 40 * h + 10) begin
            @(posedge CLK); #1;
            n++;
            if (!prev && sclk_of(s)) begin
                rx = {rx[6:0], sda_of(s)};
                if (n != (2 * rises + 2) * h) bad_rise++;
                rises++;
            end
            prev = sclk_of(s);
            if (busy_of(s) && (csn_of(s) !== data[9] || a0_of(s) !== data[8])) bad_hold++;
            if (done_of(s)) done_at = n;
        end
        if (rises != 8) bad_rise++;
        chk("bit_timing", bad_rise, 0);
        chk("csn_a0_hold", bad_hold, 0);
        chk("done_time", done_at, 17 * h);
    endtask

    task automatic start_req(input bit s, input logic [9:0] data);
        @(negedge CLK);
        if (s) begin bus1.SPI_Data = data; bus1.Start_Sig = 1'b1; end
        else   begin bus4.SPI_Data = data; bus4.Start_Sig = 1'b1; end
        @(posedge CLK); #1;
        chk("csn_valid", csn_of(s), data[9]);
        chk("a0_valid", a0_of(s), data[8]);
        chk("busy_rise", busy_of(s), 1'b1);
    endtask

    task automatic xfer(input bit s, input int h, input logic [9:0] data, output logic [7:0] rx);
        int d;
        start_req(s, data);
        watch(s, h, data, rx, d);
        if (s) bus1.Start_Sig = 1'b0; else bus4.Start_Sig = 1'b0;
        @(posedge CLK); #1;
        chk("done_width", done_of(s), 1'b0);
        chk("csn_release", csn_of(s), 1'b1);
        chk("busy_fall", busy_of(s), 1'b0);
    endtask

    logic [7:0] rx;
    int d, base;
    logic [7:0] init_seq [11] = '{8'hAF, 8'h40, 8'hA6, 8'hA0, 8'hC8, 8'hA4,
                                  8'hA2, 8'h2F, 8'h24, 8'h81, 8'h24};

    initial begin
        // Reset held while a request is pending: reset must win.
        RSTn = 1'b0;
        bus4.Start_Sig = 1'b1; bus4.SPI_Data = 10'h000;
        bus1.Start_Sig = 1'b0; bus1.SPI_Data = 10'h000;
        repeat (3) @(posedge CLK); #1;
        chk("rst_csn", csn4, 1'b1);
        chk("rst_a0", a04, 1'b1);
        chk("rst_sclk", sclk4, 1'b1);
        chk("rst_sda", sda4, 1'b0);
        chk("rst_busy", bus4.Busy_Sig, 1'b0);
        chk("rst_done", bus4.Done_Sig, 1'b0);
        @(negedge CLK);
        bus4.Start_Sig = 1'b0;
        RSTn = 1'b1;
        repeat (2) @(posedge CLK);

        // Single command byte.
        xfer(1'b0, 4, {2'b00, 8'hAF}, rx);
        chk("cmd_AF", rx, 8'hAF);

        // Display data byte: A0 must stay 1 while idle afterwards.
        xfer(1'b0, 4, {2'b01, 8'h5A}, rx);
        chk("data_5A", rx, 8'h5A);
        repeat (5) @(posedge CLK); #1;
        chk("a0_idle_hold", a04, 1'b1);
        chk("csn_idle", csn4, 1'b1);

        // Init controller replay: one request per byte, Start dropped the cycle after Done.
        base = done_cnt4;
        foreach (init_seq[i]) begin
            xfer(1'b0, 4, {2'b00, init_seq[i]}, rx);
            chk($sformatf("init_byte%0d", i), rx, init_seq[i]);
            repeat (2) @(posedge CLK);
        end
        repeat (100) @(posedge CLK); #1;
        chk("init_done_count", done_cnt4 - base, 11);

        // Back-to-back with Start held: new capture at the first edge spent in IDLE.
        start_req(1'b0, 10'h000);
        watch(1'b0, 4, 10'h000, rx, d);
        chk("b2b_first", rx, 8'h00);
        bus4.SPI_Data = 10'h0FF;
        @(posedge CLK); #1;
        chk("b2b_idle_gap", bus4.Busy_Sig, 1'b0);
        @(posedge CLK); #1;
        chk("b2b_capture", bus4.Busy_Sig, 1'b1);
        chk("b2b_csn", csn4, 1'b0);
        watch(1'b0, 4, 10'h0FF, rx, d);
        chk("b2b_second", rx, 8'hFF);
        bus4.Start_Sig = 1'b0;
        repeat (3) @(posedge CLK);

        // Reset abort at E0+30.
        start_req(1'b0, 10'h03C);
        repeat (29) @(posedge CLK); #1;
        RSTn = 1'b0;
        bus4.Start_Sig = 1'b0;
        @(posedge CLK); #1;
        chk("abort_csn", csn4, 1'b1);
        chk("abort_a0", a04, 1'b1);
        chk("abort_sclk", sclk4, 1'b1);
        chk("abort_sda", sda4, 1'b0);
        chk("abort_busy", bus4.Busy_Sig, 1'b0);
        chk("abort_done", bus4.Done_Sig, 1'b0);
        RSTn = 1'b1;
        base = done_cnt4;
        repeat (80) @(posedge CLK); #1;
        chk("abort_no_done", done_cnt4 - base, 0);
        xfer(1'b0, 4, {2'b00, 8'hC8}, rx);
        chk("after_abort_C8", rx, 8'hC8);

        // HALF_DIV=1: SCLK toggles every cycle, Done at E0+17.
        xfer(1'b1, 1, {2'b00, 8'h81}, rx);
        chk("hd1_81", rx, 8'h81);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
